// File: rtl/window_sr_pkg.sv
// Shared definitions for the sliding-window shift register: mode encodings
// and the fill-counter width helper.
package window_sr_pkg;

  localparam logic [1:0] MODE_SHIFT  = 2'b00;
  localparam logic [1:0] MODE_LOAD   = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

  // Bits needed to count 0..depth valid stages.
  function automatic int fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/window_sr_lane.sv
// One DEPTH-stage chain of DATA_W-bit registers. It supports shift, parallel
// load, rotate and clear. Stage 0 faces the serial input and stage DEPTH-1
// drives shift_out. The rotate feedback path is only built when
// WINDOW_SR_ROTATE_EN is defined. Otherwise mode 10 holds the lane.
module window_sr_lane
  import window_sr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [DATA_W-1:0]       shift_in,
  input  logic [DEPTH*DATA_W-1:0] row_in,
  output logic [DATA_W-1:0]       shift_out,
  output logic [DEPTH*DATA_W-1:0] p_out
);

  logic [DATA_W-1:0] stage_q [DEPTH];
  logic [DATA_W-1:0] stage_d [DEPTH];

  // Next-state selection for every stage of the chain.
  always_comb begin
    // NOTE: default to hold first so every path assigns stage_d; no latch.
    stage_d = stage_q;
    if (enable) begin
      case (mode)
        MODE_SHIFT: begin
          stage_d[0] = shift_in;
          for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) stage_d[i] = row_in[i*DATA_W +: DATA_W];
        end
        MODE_ROTATE: begin
`ifdef WINDOW_SR_ROTATE_EN
          stage_d[0] = stage_q[DEPTH-1];
          for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
`endif
        end
        MODE_CLEAR: begin
          for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
        end
        default: ;
      endcase
    end
  end

  // Stage registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: this array is a register chain whose reset value is visible on
    // p_out, so it is cleared on reset. It must not be treated as a RAM.
    if (!reset) begin
      stage_q <= '{default: '0};
    end else begin
      // NOTE: use non-blocking assignments so every stage samples its
      // neighbour's old value.
      stage_q <= stage_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_pout
    assign p_out[i*DATA_W +: DATA_W] = stage_q[i];
  end

  assign shift_out = stage_q[DEPTH-1];

endmodule

// File: rtl/window_shift_reg.sv
// Multi-lane sliding-window shift register. LANES identical chains share one
// control path. The top level tracks how many stages hold valid data and
// flags a full window. The rotate mode is compiled in with
// WINDOW_SR_ROTATE_EN. Without it, mode 10 is a hold.
module window_shift_reg
  import window_sr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 3,
  parameter int LANES  = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [1:0]                    mode,
  input  logic [LANES*DATA_W-1:0]       shift_in,
  input  logic [LANES*DEPTH*DATA_W-1:0] row_in,
  output logic [LANES*DATA_W-1:0]       shift_out,
  output logic [LANES*DEPTH*DATA_W-1:0] p_out,
  output logic [fill_width(DEPTH)-1:0]  fill_count,
  output logic                          window_valid
);

  localparam int FILL_W = fill_width(DEPTH);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    window_sr_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_lane (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .mode      (mode),
      .shift_in  (shift_in[l*DATA_W +: DATA_W]),
      .row_in    (row_in[l*DEPTH*DATA_W +: DEPTH*DATA_W]),
      .shift_out (shift_out[l*DATA_W +: DATA_W]),
      .p_out     (p_out[l*DEPTH*DATA_W +: DEPTH*DATA_W])
    );
  end

  // Fill level follows the mode. It saturates at DEPTH and rotate leaves it alone.
  always_comb begin
    fill_d = fill_q;
    if (enable) begin
      case (mode)
        MODE_SHIFT: if (fill_q < FULL) fill_d = fill_q + 1'b1;
        MODE_LOAD:  fill_d = FULL;
        MODE_CLEAR: fill_d = '0;
        default:    ;
      endcase
    end
  end

  // Fill level register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fill_q <= '0;
    else        fill_q <= fill_d;
  end

  assign fill_count   = fill_q;
  assign window_valid = (fill_q == FULL);

endmodule

// File: tb/tb_window_shift_reg.sv
// Self-checking bench for window_shift_reg with DEPTH=3 and LANES=2.
// The model keeps one queue per lane, where index 0 is stage 0, plus an
// integer fill level. A compare process checks every output on each falling
// edge. Directed steps also pin literal expected values.
module tb_window_shift_reg;
  import window_sr_pkg::*;

  localparam int DW = 8;
  localparam int D  = 3;
  localparam int L  = 2;

  logic              clock;
  logic              reset;
  logic              enable;
  logic [1:0]        mode;
  logic [L*DW-1:0]   shift_in;
  logic [L*D*DW-1:0] row_in;
  logic [L*DW-1:0]   shift_out;
  logic [L*D*DW-1:0] p_out;
  logic [1:0]        fill_count;
  logic              window_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mq [L][$];
  int            mfill;

  window_shift_reg #(.DATA_W(DW), .DEPTH(D), .LANES(L)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .mode         (mode),
    .shift_in     (shift_in),
    .row_in       (row_in),
    .shift_out    (shift_out),
    .p_out        (p_out),
    .fill_count   (fill_count),
    .window_valid (window_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < L; l++) begin
      mq[l] = {};
      for (int i = 0; i < D; i++) mq[l].push_back('0);
    end
    mfill = 0;
  endtask

  // Model: each lane is a window of the last D samples, newest first.
  initial begin
    model_clear();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        model_clear();
      end else if (enable) begin
        case (mode)
          MODE_SHIFT: begin
            for (int l = 0; l < L; l++) begin
              mq[l].push_front(shift_in[l*DW +: DW]);
              void'(mq[l].pop_back());
            end
            mfill = (mfill + 1 > D) ? D : mfill + 1;
          end
          MODE_LOAD: begin
            for (int l = 0; l < L; l++)
              for (int i = 0; i < D; i++) mq[l][i] = row_in[(l*D+i)*DW +: DW];
            mfill = D;
          end
          MODE_ROTATE: begin
`ifdef WINDOW_SR_ROTATE_EN
            for (int l = 0; l < L; l++) mq[l].push_front(mq[l].pop_back());
`endif
          end
          default: model_clear();
        endcase
      end
    end
  end

  // Compare all outputs against the model on every falling edge.
  always @(negedge clock) begin
    logic [L*D*DW-1:0] exp_p;
    logic [L*DW-1:0]   exp_s;
    for (int l = 0; l < L; l++) begin
      for (int i = 0; i < D; i++) exp_p[(l*D+i)*DW +: DW] = mq[l][i];
      exp_s[l*DW +: DW] = mq[l][D-1];
    end
    check("model p_out", 64'(p_out), 64'(exp_p));
    check("model shift_out", 64'(shift_out), 64'(exp_s));
    check("model fill_count", 64'(fill_count), 64'(mfill));
    check("model window_valid", 64'(window_valid), 64'(mfill == D));
  end

  task automatic step(input logic en, input logic [1:0] m,
                      input logic [L*DW-1:0] s, input logic [L*D*DW-1:0] r);
    enable   = en;
    mode     = m;
    shift_in = s;
    row_in   = r;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with garbage inputs and enable high.
    reset    = 1'b0;
    enable   = 1'b1;
    mode     = MODE_SHIFT;
    shift_in = 16'hDEAD;
    row_in   = 48'hFFFF_FFFF_FFFF;
    repeat (3) @(negedge clock);
    check("reset p_out", 64'(p_out), 64'h0);
    check("reset fill", 64'(fill_count), 64'h0);
    check("reset valid", 64'(window_valid), 64'h0);
    reset = 1'b1;

    // Two shifts, then an asynchronous reset mid-cycle.
    step(1'b1, MODE_SHIFT, 16'hA1_11, '0);
    step(1'b1, MODE_SHIFT, 16'hA2_22, '0);
    check("pre-reset fill", 64'(fill_count), 64'd2);
    enable = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async reset p_out", 64'(p_out), 64'h0);
    check("async reset fill", 64'(fill_count), 64'h0);
    check("async reset shift_out", 64'(shift_out), 64'h0);
    #1 reset = 1'b1;
    @(negedge clock);

    // Fill the window from empty.
    step(1'b1, MODE_SHIFT, 16'hA1_11, '0);
    check("fill1 valid", 64'(window_valid), 64'h0);
    step(1'b1, MODE_SHIFT, 16'hA2_22, '0);
    check("fill2 valid", 64'(window_valid), 64'h0);
    step(1'b1, MODE_SHIFT, 16'hA3_33, '0);
    check("fill3 p_out", 64'(p_out), 64'hA1A2A3_112233);
    check("fill3 shift_out0", 64'(shift_out[7:0]), 64'h11);
    check("fill3 valid", 64'(window_valid), 64'h1);
    step(1'b1, MODE_SHIFT, 16'hA4_44, '0);
    check("fill4 shift_out0", 64'(shift_out[7:0]), 64'h22);
    check("fill4 fill", 64'(fill_count), 64'd3);

    // Clear, then parallel load.
    step(1'b1, MODE_CLEAR, 16'hFFFF, '1);
    step(1'b1, MODE_LOAD, '0, 48'hB3B2B1_030201);
    check("load p_out", 64'(p_out), 64'hB3B2B1_030201);
    check("load fill", 64'(fill_count), 64'd3);
    check("load valid", 64'(window_valid), 64'h1);

    // Rotate once, then twice more to restore the loaded row.
    step(1'b1, MODE_ROTATE, 16'hFFFF, '1);
`ifdef WINDOW_SR_ROTATE_EN
    check("rotate1 lane0", 64'(p_out[23:0]), 64'h020103);
`else
    check("rotate1 lane0", 64'(p_out[23:0]), 64'h030201);
`endif
    step(1'b1, MODE_ROTATE, 16'hFFFF, '1);
    step(1'b1, MODE_ROTATE, 16'hFFFF, '1);
    check("rotate3 lane0", 64'(p_out[23:0]), 64'h030201);
    check("rotate3 fill", 64'(fill_count), 64'd3);

    // Enable low for five cycles holds everything.
    for (int k = 0; k < 5; k++) step(1'b0, MODE_SHIFT, 16'h5A5A, 48'h123456_789ABC);
    check("hold p_out", 64'(p_out), 64'hB3B2B1_030201);
    check("hold fill", 64'(fill_count), 64'd3);

    // CLEAR empties the window and drops valid.
    step(1'b1, MODE_CLEAR, 16'h5A5A, '1);
    check("clear p_out", 64'(p_out), 64'h0);
    check("clear fill", 64'(fill_count), 64'h0);
    check("clear valid", 64'(window_valid), 64'h0);

    // Back-to-back SHIFT, LOAD, SHIFT.
    step(1'b1, MODE_SHIFT, 16'hC5_55, '0);
    step(1'b1, MODE_LOAD, '0, 48'hDCDBDA_0C0B0A);
    step(1'b1, MODE_SHIFT, 16'hC7_77, '0);
    check("mix p_out", 64'(p_out), 64'hDBDAC7_0B0A77);
    check("mix fill", 64'(fill_count), 64'd3);

    step(1'b0, MODE_SHIFT, '0, '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/window_shift_reg.md
# window_shift_reg

Parametrised multi-lane shift register with parallel outputs, used to build sliding convolution windows in front of the PE array. Each lane is a DEPTH-stage chain of DATA_W-bit registers that can shift one new sample in, parallel-load a full row, rotate in place, or clear. The block tracks its fill level and flags when every stage holds valid data. All lanes share one control path.

## Interface
- DATA_W, 8, bits per stage element
- DEPTH, 3, stages per lane (≥1)
- LANES, 1, independent parallel chains (≥1)
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-low
- enable  in  1  cycle qualifier; low = hold everything
- mode  in  2  00 SHIFT, 01 LOAD, 10 ROTATE, 11 CLEAR
- shift_in  in  LANES*DATA_W  serial input, lane l at [l*DATA_W +: DATA_W]
- row_in  in  LANES*DEPTH*DATA_W  parallel load data, same indexing as p_out
- shift_out  out  LANES*DATA_W  last stage (DEPTH-1) of each lane
- p_out  out  LANES*DEPTH*DATA_W  all stages; lane l stage i at [(l*DEPTH+i)*DATA_W +: DATA_W]
- fill_count  out  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH
- window_valid  out  1  high when fill_count == DEPTH

## Operation
- Stage 0 is nearest shift_in; stage DEPTH-1 drives shift_out.
- Applies when enable=1, at the rising clock edge:
  - SHIFT: stage0 ← shift_in lane slice; stage i ← stage i-1. fill_count ← min(fill_count+1, DEPTH).
  - LOAD: stage i ← row_in slice. fill_count ← DEPTH.
  - ROTATE: stage0 ← stage DEPTH-1; stage i ← stage i-1. fill_count unchanged. DEPTH=1 is a hold.
  - CLEAR: all stages ← 0; fill_count ← 0.
- enable=0: stages and fill_count hold; mode, shift_in and row_in are ignored.
- fill_count saturates at DEPTH. It never wraps.
- All lanes execute the same mode in the same cycle.

## Timing
- Reset (asynchronous, reset=0): all stages 0, so p_out=0 and shift_out=0. fill_count=0, window_valid=0. This takes effect immediately, including mid-operation. The first update is the first rising edge with reset=1.
- Latency: one cycle. Data presented at edge N appears on p_out after edge N.
- window_valid is decoded combinationally from the fill_count register, with no extra cycle. It rises in the cycle after the DEPTH-th SHIFT following a CLEAR or reset, or in the cycle after a LOAD.
- All outputs come directly from registers, except window_valid (one comparator).

## Configuration
- Macro WINDOW_SR_ROTATE_EN.
- Defined: mode 10 performs ROTATE as specified.
- Undefined: mode 10 behaves as a hold (identical to enable=0), and the feedback muxing is not synthesised.

## Structure
- Package window_sr_pkg holds:
  - the mode encodings as localparams: MODE_SHIFT=2'b00, MODE_LOAD=2'b01, MODE_ROTATE=2'b10, MODE_CLEAR=2'b11;
  - a function computing the fill_count width from DEPTH.
- Sub-module window_sr_lane implements one DEPTH-stage chain: stage muxing, shift_out and its p_out slice. It is generated LANES times.
- The top level owns fill_count and window_valid.

## Test plan
- Reset: hold reset=0, drive garbage inputs with enable=1 → p_out=0, fill_count=0, window_valid=0. Assert reset mid-stream after 2 shifts → outputs 0 without waiting for a clock edge.
- Fill (DEPTH=3, LANES=2): SHIFT lane0 values 0x11, 0x22, 0x33 and lane1 values 0xA1, 0xA2, 0xA3.
  - After the 3rd edge: lane0 p_out = {0x11, 0x22, 0x33} (stage2..0), shift_out lane0 = 0x11, window_valid=1 and not before.
  - A 4th SHIFT of 0x44 → shift_out lane0 = 0x22, fill_count stays 3.
- LOAD: from the cleared state, LOAD row_in lane0 = {0x03, 0x02, 0x01} (stage2..0) → next cycle p_out matches, fill_count=3, window_valid=1.
- ROTATE (macro defined): after the previous load, ROTATE once → lane0 stages 0..2 = 0x03, 0x01, 0x02. Three ROTATEs restore the original. Macro undefined → contents unchanged.
- Enable/CLEAR: enable=0 with mode=SHIFT for 5 cycles → no change. Then CLEAR → all stages 0, fill_count=0, window_valid falls next cycle.
- Back-to-back mixing: SHIFT, LOAD, SHIFT on consecutive edges → after the final edge stage0 = the new sample, stages 1..DEPTH-1 = loaded stages 0..DEPTH-2, fill_count=DEPTH.
